// File: rtl/reset_sequencer_pkg.sv
// reset_sequencer_pkg: state encoding, counter sizing and default parameters
// shared by the reset sequencer and its synchronizer.
package reset_sequencer_pkg;
  typedef enum logic [1:0] {ST_WAIT_LOCK, ST_DELAY, ST_WAIT_ACK, ST_DONE} seq_state_e;
  localparam int NUM_STAGES_DEF  = 3;
  localparam int SYNC_DEPTH_DEF  = 2;
  localparam int LOCK_FILTER_DEF = 8;
  localparam int STAGE_DELAY_DEF = 16;
  localparam int ACK_TIMEOUT_DEF = 256;
  function automatic int cnt_w(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction
endpackage

// File: rtl/reset_seq_bit_sync.sv
// reset_seq_bit_sync: SYNC_DEPTH-flop single-bit synchronizer, cleared to 0 by reset_n.
module reset_seq_bit_sync #(
  parameter int SYNC_DEPTH = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic d,
  output logic q
);
  (* preserve *) logic [SYNC_DEPTH-1:0] sync_q;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) sync_q <= '0;
    else sync_q <= {sync_q[SYNC_DEPTH-2:0], d};
  assign q = sync_q[SYNC_DEPTH-1];
endmodule

// File: rtl/reset_sequencer.sv
// reset_sequencer: releases NUM_STAGES reset domains in index order once PLL lock
// is stable, waiting (with timeout) for each stage's ack before the next release.
module reset_sequencer
  import reset_sequencer_pkg::*;
#(
  parameter int NUM_STAGES  = NUM_STAGES_DEF,
  parameter int SYNC_DEPTH  = SYNC_DEPTH_DEF,
  parameter int LOCK_FILTER = LOCK_FILTER_DEF,
  parameter int STAGE_DELAY = STAGE_DELAY_DEF,
  parameter int ACK_TIMEOUT = ACK_TIMEOUT_DEF
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  pll_locked,
  input  logic                  soft_reset_req,
  input  logic [NUM_STAGES-1:0] stage_ack,
  output logic [NUM_STAGES-1:0] reset_out,
  output logic                  seq_done,
  output logic                  timeout_err
);
  localparam int FW = cnt_w(LOCK_FILTER);
  localparam int DW = cnt_w(STAGE_DELAY);
  localparam int TW = cnt_w(ACK_TIMEOUT);
  localparam int IW = cnt_w(NUM_STAGES - 1);
  seq_state_e            state_q, state_d;
  logic [FW-1:0]         filt_q, filt_d;
  logic [DW-1:0]         dly_q, dly_d;
  logic [TW-1:0]         to_q, to_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [NUM_STAGES-1:0] reset_d;
  logic                  lock_s, abort, ack, expired, last, err_d, done_d;
  reset_seq_bit_sync #(.SYNC_DEPTH(SYNC_DEPTH)) u_lock_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (pll_locked),
    .q       (lock_s)
  );
  assign abort   = soft_reset_req || (!lock_s && state_q != ST_WAIT_LOCK);
  assign ack     = stage_ack[idx_q];
  assign expired = to_q == TW'(ACK_TIMEOUT);
  assign last    = idx_q == IW'(NUM_STAGES - 1);
  assign done_d  = (state_q == ST_DONE) && !abort;
  // Counters are cleared on every exit from their state, so each bound is reached exactly once.
  always_comb begin
    state_d = state_q;
    filt_d  = filt_q;
    dly_d   = dly_q;
    to_d    = to_q;
    idx_d   = idx_q;
    reset_d = reset_out;
    err_d   = timeout_err;
    case (state_q)
      ST_WAIT_LOCK: begin
        filt_d = lock_s ? filt_q + 1'b1 : '0;
        if (lock_s && filt_q == FW'(LOCK_FILTER - 1)) begin
          state_d = ST_DELAY;
          filt_d  = '0;
          idx_d   = '0;
        end
      end
      ST_DELAY: begin
        dly_d = dly_q + 1'b1;
        if (dly_q == DW'(STAGE_DELAY - 1)) begin
          state_d        = ST_WAIT_ACK;
          dly_d          = '0;
          to_d           = TW'(1);
          reset_d[idx_q] = 1'b0;
        end
      end
      ST_WAIT_ACK: begin
        to_d = to_q + 1'b1;
        if (ack || expired) begin
          err_d   = timeout_err | ~ack;
          to_d    = '0;
          state_d = last ? ST_DONE : ST_DELAY;
          idx_d   = last ? idx_q : idx_q + 1'b1;
        end
      end
      default: ;
    endcase
    if (abort) begin
      state_d = ST_WAIT_LOCK;
      filt_d  = '0;
      dly_d   = '0;
      to_d    = '0;
      idx_d   = '0;
      reset_d = '1;
      err_d   = timeout_err;
    end
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state_q     <= ST_WAIT_LOCK;
      filt_q      <= '0;
      dly_q       <= '0;
      to_q        <= '0;
      idx_q       <= '0;
      reset_out   <= '1;
      seq_done    <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      state_q     <= state_d;
      filt_q      <= filt_d;
      dly_q       <= dly_d;
      to_q        <= to_d;
      idx_q       <= idx_d;
      reset_out   <= reset_d;
      seq_done    <= done_d;
      timeout_err <= err_d;
    end
endmodule

// File: tb/tb_reset_sequencer.sv
// tb_reset_sequencer: checks reset_sequencer against a release-schedule model that
// computes each stage's release edge, the done edge and the first timeout edge.
module tb_reset_sequencer;
  localparam int NS = 3, SD = 2, LF = 8, DL = 16, AT = 256;
  localparam int INF = 1_000_000_000, NEVER = 1_000_000;
  logic clk = 1'b0, reset_n = 1'b1, pll_locked = 1'b1, soft_reset_req = 1'b0;
  logic [NS-1:0] stage_ack, reset_out;
  logic seq_done, timeout_err;
  int checks = 0, errors = 0, cyc = 0, abort_at = -1, restart_f = -1, done_e = INF, err_e = INF;
  int rel [NS];
  int d [NS];
  always #5 clk = ~clk;
  reset_sequencer #(.NUM_STAGES(NS), .SYNC_DEPTH(SD), .LOCK_FILTER(LF), .STAGE_DELAY(DL), .ACK_TIMEOUT(AT)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .pll_locked     (pll_locked),
    .soft_reset_req (soft_reset_req),
    .stage_ack      (stage_ack),
    .reset_out      (reset_out),
    .seq_done       (seq_done),
    .timeout_err    (timeout_err)
  );
  // f is the edge after which the lock filter starts counting from zero with lock held.
  task automatic start(input int f);
    int t = f + LF + DL, s = 0;
    for (int k = 0; k < NS; k++) begin
      rel[k] = t;
      s = t + ((d[k] > AT) ? AT : d[k]);
      if (d[k] > AT && s < err_e) err_e = s;
      t = s + DL;
    end
    done_e = s + 1;
  endtask
  task automatic kill(input int a);
    for (int k = 0; k < NS; k++) rel[k] = INF;
    done_e = INF;
    if (err_e >= a) err_e = INF;
  endtask
  task automatic check();
    logic [NS-1:0] e;
    for (int k = 0; k < NS; k++) e[k] = cyc < rel[k];
    checks++;
    assert (reset_out === e) else begin errors++; $error("FAIL reset_out @%0d: got %b, expected %b", cyc, reset_out, e); end
    checks++;
    assert (seq_done === (cyc >= done_e)) else begin errors++; $error("FAIL seq_done @%0d: got %b, expected %b", cyc, seq_done, cyc >= done_e); end
    checks++;
    assert (timeout_err === (cyc >= err_e)) else begin errors++; $error("FAIL timeout_err @%0d: got %b, expected %b", cyc, timeout_err, cyc >= err_e); end
  endtask
  task automatic check_rst();
    checks++;
    assert (reset_out === '1) else begin errors++; $error("FAIL rst reset_out: got %b, expected 111", reset_out); end
    checks++;
    assert (seq_done === 1'b0) else begin errors++; $error("FAIL rst seq_done: got %b, expected 0", seq_done); end
    checks++;
    assert (timeout_err === 1'b0) else begin errors++; $error("FAIL rst timeout_err: got %b, expected 0", timeout_err); end
  endtask
  task automatic step();
    for (int k = 0; k < NS; k++) stage_ack[k] = (cyc >= rel[k] + d[k] - 1) && (cyc < done_e + 2);
    @(posedge clk);
    #1;
    cyc++;
    if (cyc == abort_at) begin
      kill(cyc);
      if (restart_f >= 0) start(restart_f);
      abort_at = -1;
    end
    check();
  endtask
  task automatic run_until(input int e);
    int lim = cyc + 5000;
    while (cyc < e && cyc < lim) step();
    checks++;
    assert (cyc >= e) else begin errors++; $error("FAIL run_until: reached %0d, target %0d", cyc, e); end
  endtask
  task automatic soft_pulse();
    soft_reset_req = 1'b1;
    abort_at = cyc + 1;
    restart_f = cyc + 1;
    step();
    soft_reset_req = 1'b0;
  endtask
  task automatic hard_reset(input bit on_edge);
    if (on_edge) @(posedge clk);
    else #2;
    reset_n = 1'b0;
    #1;
    check_rst();
    @(posedge clk);
    #1;
    check_rst();
    reset_n = 1'b1;
    cyc = 0;
    abort_at = -1;
    kill(0);
  endtask
  initial begin
    stage_ack = '0;
    for (int k = 0; k < NS; k++) begin d[k] = 1; rel[k] = INF; end
    #1 reset_n = 1'b0;
    #1 check_rst();
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    cyc = 0;
    start(SD);
    run_until(done_e + 5);
    d = '{3, AT, 5};
    soft_pulse();
    run_until(done_e + 5);
    d = '{1, NEVER, 1};
    soft_pulse();
    run_until(done_e + 5);
    d = '{2, 100, 4};
    soft_pulse();
    run_until(rel[1] + 5);
    pll_locked = 1'b0;
    abort_at = cyc + SD + 1;
    restart_f = cyc + 3 + SD;
    repeat (3) step();
    pll_locked = 1'b1;
    run_until(done_e + 5);
    d = '{4, 1, 1};
    soft_pulse();
    run_until(rel[0] + d[0] - 1);
    soft_pulse();
    run_until(done_e + 5);
    for (int it = 0; it < 8; it++) begin
      for (int k = 0; k < NS; k++)
        case ($urandom_range(0, 4))
          0: d[k] = AT - 1;
          1: d[k] = AT;
          2: d[k] = AT + 1;
          default: d[k] = int'($urandom_range(1, 40));
        endcase
      soft_pulse();
      run_until(cyc + int'($urandom_range(5, 900)));
    end
    d = '{1, 1, NEVER};
    soft_pulse();
    run_until(done_e + 3);
    pll_locked = 1'b0;
    hard_reset(1'b1);
    for (int p = 0; p < 10; p++) begin
      pll_locked = 1'b1;
      repeat (7) step();
      pll_locked = 1'b0;
      repeat ($urandom_range(1, 3)) step();
    end
    d = '{1, AT + 1, 1};
    pll_locked = 1'b1;
    start(cyc + SD);
    run_until(done_e + 3);
    hard_reset(1'b0);
    d = '{1, 1, 1};
    start(SD);
    run_until(done_e + 3);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
